// File: rtl/mac_layer_sequencer.sv
// Address/strobe sequencer for one fully-connected layer on a single shared MAC.
// Latency: first FETCH one cycle after start; each neuron takes N_IN+RD_LAT+MAC_LAT cycles.
// No backpressure: start is only sampled in IDLE, and the schedule is fixed once started.
module mac_layer_sequencer #(
  parameter int N_IN    = 784,
  parameter int N_OUT   = 10,
  parameter int IN_AW   = 10,
  parameter int W_AW    = 13,
  parameter int OUT_AW  = 4,
  parameter int RD_LAT  = 2,
  parameter int MAC_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [IN_AW-1:0]  in_addr,
  output logic [W_AW-1:0]   w_addr,
  output logic              acc_valid,
  output logic              acc_first,
  output logic              out_wr,
  output logic [OUT_AW-1:0] out_addr
);

  localparam int DRAIN_N = RD_LAT + MAC_LAT - 1;
  localparam int DCW     = (DRAIN_N > 1) ? $clog2(DRAIN_N) : 1;

  localparam logic [IN_AW-1:0]  I_LAST = IN_AW'(N_IN - 1);
  localparam logic [OUT_AW-1:0] N_LAST = OUT_AW'(N_OUT - 1);
  localparam logic [DCW-1:0]    D_LAST = DCW'(DRAIN_N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  state_t              state_q;
  logic                busy_q;
  logic                done_q;
  logic                rd_en_q;
  logic                out_wr_q;
  logic [IN_AW-1:0]    in_addr_q;
  logic [W_AW-1:0]     w_addr_q;
  logic [OUT_AW-1:0]   out_addr_q;
  logic [DCW-1:0]      drain_cnt_q;
  logic [RD_LAT-1:0]   vld_pipe_q;
  logic [RD_LAT-1:0]   first_pipe_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rd_en_q      <= 1'b0;
      out_wr_q     <= 1'b0;
      in_addr_q    <= '0;
      w_addr_q     <= '0;
      out_addr_q   <= '0;
      drain_cnt_q  <= '0;
      vld_pipe_q   <= '0;
      first_pipe_q <= '0;
    end else begin
      done_q   <= 1'b0;
      out_wr_q <= 1'b0;

      // Strobes follow the read by exactly the memory read latency.
      vld_pipe_q[0]   <= rd_en_q;
      first_pipe_q[0] <= rd_en_q && (in_addr_q == '0);
      for (int k = 1; k < RD_LAT; k++) begin
        vld_pipe_q[k]   <= vld_pipe_q[k-1];
        first_pipe_q[k] <= first_pipe_q[k-1];
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_FETCH;
            busy_q     <= 1'b1;
            rd_en_q    <= 1'b1;
            in_addr_q  <= '0;
            w_addr_q   <= '0;
            out_addr_q <= '0;
          end
        end
        S_FETCH: begin
          // Weights are stored neuron-major, so w_addr simply runs on across neurons.
          w_addr_q <= w_addr_q + W_AW'(1);
          if (in_addr_q == I_LAST) begin
            in_addr_q   <= '0;
            rd_en_q     <= 1'b0;
            drain_cnt_q <= '0;
            state_q     <= S_DRAIN;
          end else begin
            in_addr_q <= in_addr_q + IN_AW'(1);
          end
        end
        S_DRAIN: begin
          if (drain_cnt_q == D_LAST) begin
            state_q  <= S_WRITE;
            out_wr_q <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q + DCW'(1);
          end
        end
        S_WRITE: begin
          if (out_addr_q == N_LAST) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            out_addr_q <= out_addr_q + OUT_AW'(1);
            rd_en_q    <= 1'b1;
            state_q    <= S_FETCH;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_en     = rd_en_q;
  assign in_addr   = in_addr_q;
  assign w_addr    = w_addr_q;
  assign out_wr    = out_wr_q;
  assign out_addr  = out_addr_q;
  assign acc_valid = vld_pipe_q[RD_LAT-1];
  assign acc_first = first_pipe_q[RD_LAT-1];

endmodule

// File: tb/tb_mac_layer_sequencer.sv
// Bench for mac_layer_sequencer: directed scenarios then random start/reset traffic,
// expected events queued by a schedule-based model and popped by an independent monitor.
module tb_mac_layer_sequencer;

  localparam int N_IN    = 4;
  localparam int N_OUT   = 3;
  localparam int IN_AW   = 2;
  localparam int W_AW    = 4;
  localparam int OUT_AW  = 2;
  localparam int RD_LAT  = 2;
  localparam int MAC_LAT = 1;
  localparam int P       = N_IN + RD_LAT + MAC_LAT;
  localparam int RUN_LEN = N_OUT * P + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [IN_AW-1:0]  in_addr;
  logic [W_AW-1:0]   w_addr;
  logic              acc_valid;
  logic              acc_first;
  logic              out_wr;
  logic [OUT_AW-1:0] out_addr;

  mac_layer_sequencer #(
    .N_IN(N_IN), .N_OUT(N_OUT), .IN_AW(IN_AW), .W_AW(W_AW),
    .OUT_AW(OUT_AW), .RD_LAT(RD_LAT), .MAC_LAT(MAC_LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .in_addr(in_addr), .w_addr(w_addr),
    .acc_valid(acc_valid), .acc_first(acc_first),
    .out_wr(out_wr), .out_addr(out_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int a;
    int b;
  } ev_t;

  ev_t q_stat[$];
  ev_t q_rd[$];
  ev_t q_acc[$];
  ev_t q_wr[$];
  ev_t q_done[$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit armed = 1'b0;

  // Model state: cycle in which the current run's start was accepted, -1 if none.
  int run_s = -1;
  bit zero_next = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic stray(input string nm);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d: unexpected strobe, got 1, expected 0", nm, cyc);
  endtask

  // Expected outputs for cycle c from the layer schedule: neuron n owns cycles
  // run_s+1+n*P .. run_s+(n+1)*P; first N_IN fetch, last one writes; DONE follows.
  task automatic expect_cycle(input int c, output bit busy_e);
    int t, t2, n, k;
    busy_e = 1'b0;
    t = (run_s >= 0) ? c - run_s : -1000;
    if (t >= 1 && t <= RUN_LEN) busy_e = 1'b1;
    q_stat.push_back('{c, int'(busy_e), int'(zero_next)});
    if (t >= 1 && t < RUN_LEN) begin
      n = (t - 1) / P;
      k = (t - 1) % P;
      if (k < N_IN) q_rd.push_back('{c, k, n * N_IN + k});
      if (k == P - 1) q_wr.push_back('{c, n, 0});
    end
    if (t == RUN_LEN) q_done.push_back('{c, 0, 0});
    t2 = t - RD_LAT;
    if (t2 >= 1 && t2 < RUN_LEN && ((t2 - 1) % P) < N_IN)
      q_acc.push_back('{c, int'(((t2 - 1) % P) == 0), 0});
  endtask

  task automatic step(input bit st, input bit r);
    bit b;
    @(negedge clk);
    expect_cycle(cyc, b);
    start = st;
    rst = r;
    zero_next = r;
    if (r) run_s = -1;
    else if (!b && st) run_s = cyc;
  endtask

  task automatic monitor_cycle();
    ev_t e;
    if (q_stat.size() == 0) stray("status");
    else begin
      e = q_stat.pop_front();
      check("busy", int'(busy), e.a);
      if (e.b != 0) begin
        check("reset_done", int'(done), 0);
        check("reset_rd_en", int'(rd_en), 0);
        check("reset_in_addr", int'(in_addr), 0);
        check("reset_w_addr", int'(w_addr), 0);
        check("reset_acc_valid", int'(acc_valid), 0);
        check("reset_acc_first", int'(acc_first), 0);
        check("reset_out_wr", int'(out_wr), 0);
        check("reset_out_addr", int'(out_addr), 0);
      end
    end
    if (rd_en) begin
      if (q_rd.size() == 0) stray("rd_en");
      else begin
        e = q_rd.pop_front();
        check("rd_cycle", cyc, e.cyc);
        check("in_addr", int'(in_addr), e.a);
        check("w_addr", int'(w_addr), e.b);
      end
    end
    if (acc_valid) begin
      if (q_acc.size() == 0) stray("acc_valid");
      else begin
        e = q_acc.pop_front();
        check("acc_cycle", cyc, e.cyc);
        check("acc_first", int'(acc_first), e.a);
      end
    end else if (acc_first) begin
      stray("acc_first_without_valid");
    end
    if (out_wr) begin
      if (q_wr.size() == 0) stray("out_wr");
      else begin
        e = q_wr.pop_front();
        check("wr_cycle", cyc, e.cyc);
        check("out_addr", int'(out_addr), e.a);
      end
    end
    if (done) begin
      if (q_done.size() == 0) stray("done");
      else begin
        e = q_done.pop_front();
        check("done_cycle", cyc, e.cyc);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (armed) monitor_cycle();
    end
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    armed = 1'b1;

    // Single start pulse, with a second pulse mid-run that must be ignored.
    step(1'b1, 1'b0);
    for (int i = 1; i < 30; i++) step(i == 10, 1'b0);

    // Reset nine cycles into a run, then a clean restart.
    step(1'b1, 1'b0);
    for (int i = 1; i < 9; i++) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (25) step(1'b0, 1'b0);

    // start held high: back-to-back layers with one IDLE cycle between.
    repeat (60) step(1'b1, 1'b0);

    // Random start/reset traffic.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(7) == 0, $urandom_range(199) == 0);
    repeat (30) step(1'b0, 1'b0);

    #2;
    armed = 1'b0;
    checks++;
    if (q_stat.size() + q_rd.size() + q_acc.size() + q_wr.size() + q_done.size() != 0) begin
      errors++;
      $display("FAIL missing_events: got %0d outstanding, expected 0",
               q_stat.size() + q_rd.size() + q_acc.size() + q_wr.size() + q_done.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_layer_sequencer.md
Name: mac_layer_sequencer

Overview:
- Sequences one fully-connected layer on the shared single-MAC datapath.
- For each output neuron n, streams N_IN input/weight read addresses and generates aligned accumulator first/valid strobes.
- Waits for the accumulator pipeline to drain, then issues one output write; repeats for N_OUT neurons.
- Sits between the layer-level control (start/done) and the input RAM, weight ROM, multiplier-accumulator and output buffer.

Parameters:
- N_IN, 784, inputs per neuron (>=1)
- N_OUT, 10, neurons in the layer (>=1)
- IN_AW, 10, input RAM address width (2**IN_AW >= N_IN)
- W_AW, 13, weight ROM address width (2**W_AW >= N_IN*N_OUT)
- OUT_AW, 4, output buffer address width (2**OUT_AW >= N_OUT)
- RD_LAT, 2, cycles from rd_en to operands at multiplier input (>=1)
- MAC_LAT, 1, cycles from acc_valid to the accumulator output holding that term (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin layer; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the layer completes
- rd_en  out  1  read strobe to input RAM and weight ROM
- in_addr  out  IN_AW  input index i
- w_addr  out  W_AW  weight address, n*N_IN+i
- acc_valid  out  1  product valid at accumulator this cycle
- acc_first  out  1  with acc_valid: load the product instead of adding (first term of neuron)
- out_wr  out  1  write accumulator result to output buffer
- out_addr  out  OUT_AW  neuron index n

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk. All state and outputs are registered or decoded from registered state.
- Reset: state=IDLE; busy, done, rd_en, acc_valid, acc_first, out_wr = 0; in_addr, w_addr, out_addr = 0; delay pipelines cleared. Reset mid-layer aborts immediately; no strobes are emitted afterwards.
- FSM states: IDLE, FETCH, DRAIN, WRITE, DONE.
- IDLE: when start=1, set i=0, n=0, w_addr=0; next state FETCH.
- FETCH: rd_en=1 with the current in_addr=i and w_addr.
  - Each cycle, i and w_addr increment.
  - When i==N_IN-1, next state DRAIN; i resets to 0, w_addr keeps incrementing (neuron-major layout, no multiplier).
- DRAIN: lasts exactly RD_LAT+MAC_LAT-1 cycles, counted by a drain counter. rd_en=0. Next state WRITE.
- WRITE: out_wr=1 for one cycle with out_addr=n.
  - If n==N_OUT-1, next state DONE.
  - Otherwise n increments and next state FETCH.
- DONE: done=1 for one cycle; next state IDLE.
- Strobe alignment:
  - acc_valid is rd_en delayed by RD_LAT cycles.
  - acc_first is (rd_en and i==0) delayed by RD_LAT cycles.
- Timing: let T be the last FETCH cycle of a neuron. Its last acc_valid is at T+RD_LAT and out_wr is at T+RD_LAT+MAC_LAT. Each neuron takes N_IN+RD_LAT+MAC_LAT cycles.
- Overall latency: start sampled in cycle 0.
  - First FETCH of neuron n is at cycle 1+n*(N_IN+RD_LAT+MAC_LAT).
  - done is at cycle 1+N_OUT*(N_IN+RD_LAT+MAC_LAT); with defaults, cycle 7871.
- busy is high from cycle 1 through the DONE cycle inclusive.
- start while busy is ignored. start held high across DONE retriggers on the IDLE cycle after done.
- acc_valid never overlaps out_wr for the same neuron. The next neuron's acc_first arrives RD_LAT+1 cycles after its out_wr.

Test Plan:
- Small layer (N_IN=4, N_OUT=3, RD_LAT=2, MAC_LAT=1), start pulse at cycle 0 ->
  - rd_en high cycles 1-4, 8-11, 15-18.
  - w_addr 0-3, 4-7, 8-11; in_addr 0-3 repeating.
  - out_wr at cycles 7, 14, 21 with out_addr 0, 1, 2.
  - done at cycle 22; busy cycles 1-22.
- Same run, check strobes ->
  - acc_valid high cycles 3-6, 10-13, 17-20.
  - acc_first only at cycles 3, 10, 17.
- start pulsed again at cycle 10 during the run -> ignored; waveform identical to the first scenario.
- rst asserted at cycle 9 for one cycle ->
  - From cycle 10: all outputs 0, state IDLE; no stray acc_valid or out_wr.
  - A new start then reproduces the first scenario's waveform.
- Degenerate N_IN=1, N_OUT=1, RD_LAT=1, MAC_LAT=1 -> rd_en cycle 1, acc_valid and acc_first cycle 2, out_wr cycle 3, done cycle 4.
- start held high continuously -> done at 22; layer restarts with first FETCH at cycle 24 (IDLE at 23).
